// File: rtl/led_pkg.sv
// Shared types and helpers for the LED pattern generator: pattern mode
// encodings, bounce direction and the per-mode starting pattern.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT  = 2'd0,
        MODE_WALK   = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Widest LED bank the seed helper can describe; callers truncate to their width.
    localparam int MAX_LEDS = 64;

    // Starting pattern for a mode: a single lit LSB for the moving patterns,
    // all dark for counting and blinking. Bits at or above n are cleared.
    function automatic logic [MAX_LEDS-1:0] mode_seed(input mode_t mode, input int n);
        logic [MAX_LEDS-1:0] seed;
        case (mode)
            MODE_WALK, MODE_BOUNCE: seed = MAX_LEDS'(1);
            default:                seed = '0;
        endcase
        for (int i = 0; i < MAX_LEDS; i++) begin
            if (i >= n) begin
                seed[i] = 1'b0;
            end
        end
        return seed;
    endfunction

endpackage

// File: rtl/led_pwm.sv
// Global brightness stage: a free-running PWM counter gates the whole
// pattern on or off each cycle, and the result is registered onto the pins.
module led_pwm
    import led_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int PWM_BITS = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [NUM_LEDS-1:0] pat,
    input  logic [PWM_BITS-1:0] Duty,
    output logic [NUM_LEDS-1:0] Leds
);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic                on;

    // All-ones duty means fully lit, so it must not lose the last slot of the period.
    assign on = (Duty == '1) || (pwm_cnt < Duty);

    // PWM counter runs regardless of Enable so a frozen pattern stays visible.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pwm_cnt <= '0;
            Leds    <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            Leds    <= pat & {NUM_LEDS{on}};
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern driver: a clock-enable prescaler paces one of four patterns
// (count, walk, bounce, blink) which is then dimmed by a global PWM duty.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int TICK_DIV = 50_000_000,
    parameter int PWM_BITS = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Enable,
    input  logic [1:0]          Mode,
    input  logic [PWM_BITS-1:0] Duty,
    output logic [NUM_LEDS-1:0] Leds,
    output logic                Tick
);

    localparam int                 PRESC_W    = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

    logic [PRESC_W-1:0]  presc;
    mode_t               mode_in;
    mode_t               mode_q;
    dir_t                dir;
    logic [NUM_LEDS-1:0] pat;
    logic [NUM_LEDS-1:0] pat_seed;
    logic                step;
    logic                mode_change;

    assign mode_in     = mode_t'(Mode);
    assign mode_change = (mode_in != mode_q);
    assign step        = Enable && (presc == PRESC_LAST);
    assign pat_seed    = NUM_LEDS'(mode_seed(mode_in, NUM_LEDS));

    // Prescaler: restarts on a mode change so the new pattern gets a full first interval.
    always_ff @(posedge Clk) begin
        if (Reset || mode_change) begin
            presc <= '0;
        end else if (Enable) begin
            if (step) begin
                presc <= '0;
            end else begin
                presc <= presc + PRESC_W'(1);
            end
        end
    end

    // Pattern/direction FSM: a mode change reseeds and swallows any coincident step.
    always_ff @(posedge Clk) begin
        if (Reset || mode_change) begin
            mode_q <= mode_in;
            pat    <= pat_seed;
            dir    <= DIR_UP;
            Tick   <= 1'b0;
        end else if (step) begin
            Tick <= 1'b1;
            case (mode_q)
                MODE_COUNT: begin
                    pat <= pat + NUM_LEDS'(1);
                end
                MODE_WALK: begin
                    pat <= {pat[NUM_LEDS-2:0], pat[NUM_LEDS-1]};
                end
                MODE_BOUNCE: begin
                    if (dir == DIR_UP) begin
                        if (pat[NUM_LEDS-1]) begin
                            dir <= DIR_DOWN;
                            pat <= pat >> 1;
                        end else begin
                            pat <= pat << 1;
                        end
                    end else begin
                        if (pat[0]) begin
                            dir <= DIR_UP;
                            pat <= pat << 1;
                        end else begin
                            pat <= pat >> 1;
                        end
                    end
                end
                MODE_BLINK: begin
                    pat <= ~pat;
                end
            endcase
        end else begin
            Tick <= 1'b0;
        end
    end

    led_pwm #(
        .NUM_LEDS (NUM_LEDS),
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .Clk   (Clk),
        .Reset (Reset),
        .pat   (pat),
        .Duty  (Duty),
        .Leds  (Leds)
    );

endmodule

// File: tb/tb_led_pattern_gen.sv
// Testbench for led_pattern_gen with a small 4-LED, 4-cycle-step, 2-bit PWM build.
module tb_led_pattern_gen;
    import led_pkg::*;

    localparam int N  = 4;
    localparam int TD = 4;
    localparam int PB = 2;

    logic          Clk    = 1'b0;
    logic          Reset  = 1'b1;
    logic          Enable = 1'b1;
    logic [1:0]    Mode   = 2'd0;
    logic [PB-1:0] Duty   = 2'd3;
    logic [N-1:0]  Leds;
    logic          Tick;

    typedef struct {
        logic [1:0]   mode;
        logic [N-1:0] pat;
    } vec_t;

    vec_t         vecs[$];
    logic [N-1:0] exp_q[$];
    logic [N-1:0] model_pat;
    logic [N-1:0] led_mask;
    int           vectors     = 0;
    int           miscompares = 0;

    led_pattern_gen #(
        .NUM_LEDS (N),
        .TICK_DIV (TD),
        .PWM_BITS (PB)
    ) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Enable (Enable),
        .Mode   (Mode),
        .Duty   (Duty),
        .Leds   (Leds),
        .Tick   (Tick)
    );

    // Free-running board clock.
    always #5 Clk = ~Clk;

    // Safety net so a stuck run still ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // One clock: the expected Leds (pattern held before this edge, gated) is queued, then checked.
    task automatic clk_check(input string name, input logic exp_tick);
        logic [N-1:0] exp_leds;
        exp_q.push_back(model_pat & led_mask);
        @(posedge Clk);
        #1;
        exp_leds = exp_q.pop_front();
        check_output({name, " leds"}, {28'd0, Leds}, {28'd0, exp_leds});
        check_output({name, " tick"}, {31'd0, Tick}, {31'd0, exp_tick});
    endtask

    // One full step interval starting right after a step/reset/mode-change edge.
    task automatic wait_step(input string name, input logic [N-1:0] next_pat);
        for (int c = 0; c < TD - 1; c++) begin
            clk_check(name, 1'b0);
        end
        clk_check(name, 1'b1);
        model_pat = next_pat;
    endtask

    task automatic apply_stimulus(input logic [1:0] mode, input logic [N-1:0] seed);
        Reset = 1'b1;
        Mode  = mode;
        @(posedge Clk);
        #1;
        check_output("reset leds", {28'd0, Leds}, 32'd0);
        check_output("reset tick", {31'd0, Tick}, 32'd0);
        Reset = 1'b0;
        exp_q.delete();
        model_pat = seed;
    endtask

    initial begin
        int on_cnt;
        int zero_cnt;
        int first_on;
        int gap;

        led_mask = '1;

        vecs.push_back('{MODE_COUNT, 4'b0000});
        for (int i = 1; i <= 17; i++) begin
            vecs.push_back('{MODE_COUNT, N'(i)});
        end
        vecs.push_back('{MODE_BOUNCE, 4'b0001});
        vecs.push_back('{MODE_BOUNCE, 4'b0010});
        vecs.push_back('{MODE_BOUNCE, 4'b0100});
        vecs.push_back('{MODE_BOUNCE, 4'b1000});
        vecs.push_back('{MODE_BOUNCE, 4'b0100});
        vecs.push_back('{MODE_BOUNCE, 4'b0010});
        vecs.push_back('{MODE_BOUNCE, 4'b0001});
        vecs.push_back('{MODE_BOUNCE, 4'b0010});
        vecs.push_back('{MODE_WALK,   4'b0001});
        vecs.push_back('{MODE_WALK,   4'b0010});
        vecs.push_back('{MODE_WALK,   4'b0100});
        vecs.push_back('{MODE_WALK,   4'b1000});
        vecs.push_back('{MODE_WALK,   4'b0001});
        vecs.push_back('{MODE_BLINK,  4'b0000});
        vecs.push_back('{MODE_BLINK,  4'b1111});
        vecs.push_back('{MODE_BLINK,  4'b0000});
        vecs.push_back('{MODE_BLINK,  4'b1111});

        // Table: first entry of each mode is the reset seed, the rest are successive steps.
        for (int i = 0; i < vecs.size(); i++) begin
            if (i == 0) begin
                apply_stimulus(vecs[i].mode, vecs[i].pat);
            end else if (vecs[i].mode != vecs[i-1].mode) begin
                clk_check("last pattern", 1'b0);
                apply_stimulus(vecs[i].mode, vecs[i].pat);
            end else begin
                wait_step($sformatf("vec%0d", i), vecs[i].pat);
            end
        end
        clk_check("table tail", 1'b0);

        // WALK with a switch to BLINK on the very edge a step would land.
        apply_stimulus(MODE_WALK, 4'b0001);
        for (int c = 0; c < TD - 1; c++) begin
            clk_check("walk pre", 1'b0);
        end
        Mode = MODE_BLINK;
        clk_check("mode change", 1'b0);
        model_pat = 4'b0000;
        wait_step("blink1", 4'b1111);
        wait_step("blink2", 4'b0000);
        clk_check("blink tail", 1'b0);

        // Enable low for 5 cycles mid-interval stretches the step by 5.
        apply_stimulus(MODE_COUNT, 4'b0000);
        wait_step("en first", 4'b0001);
        clk_check("en mid", 1'b0);
        clk_check("en mid", 1'b0);
        Enable = 1'b0;
        for (int c = 0; c < 5; c++) begin
            clk_check("enable low", 1'b0);
        end
        Enable = 1'b1;
        clk_check("en resume", 1'b0);
        clk_check("en resume", 1'b1);
        model_pat = 4'b0010;
        clk_check("en after", 1'b0);

        // PWM dimming on a frozen all-ones pattern.
        apply_stimulus(MODE_BLINK, 4'b0000);
        wait_step("pwm prep", 4'b1111);
        Enable   = 1'b0;
        Duty     = 2'd1;
        on_cnt   = 0;
        zero_cnt = 0;
        first_on = -1;
        gap      = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge Clk);
            #1;
            if (Leds === 4'b1111) begin
                on_cnt++;
                if (first_on < 0) first_on = c;
                else gap = c - first_on;
            end else if (Leds === 4'b0000) begin
                zero_cnt++;
            end
        end
        check_output("duty1 on count", on_cnt, 2);
        check_output("duty1 off count", zero_cnt, 6);
        check_output("duty1 spacing", gap, 4);
        Duty     = 2'd0;
        led_mask = 4'b0000;
        for (int c = 0; c < 8; c++) begin
            clk_check("duty0", 1'b0);
        end
        Duty     = 2'd3;
        led_mask = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            clk_check("duty3", 1'b0);
        end
        Enable = 1'b1;

        // Reset landing on the edge where COUNT would step from 5.
        apply_stimulus(MODE_COUNT, 4'b0000);
        for (int k = 1; k <= 5; k++) begin
            wait_step("pre reset", N'(k));
        end
        for (int c = 0; c < TD - 1; c++) begin
            clk_check("pre reset hold", 1'b0);
        end
        apply_stimulus(MODE_COUNT, 4'b0000);
        wait_step("post reset", 4'b0001);
        clk_check("post reset tail", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
